therm_plant: RTL and testbench

THERM_PLANT -- requirements
Module: therm_plant

---
 rtl/therm_pkg.sv | 13 +
 rtl/therm_rate_div.sv | 26 ++
 rtl/therm_plant.sv | 117 +++++++++++
 tb/tb_therm_plant.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/therm_pkg.sv
// Shared types and widths for the thermal plant model.
package therm_pkg;

    localparam int unsigned TW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEATING = 2'b01,
        COOLING = 2'b10
    } state_t;

endpackage

// File: rtl/therm_rate_div.sv
// Clearable modulo counter; tick is high during the cycle whose edge wraps the count.
module therm_rate_div
    import therm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [CW-1:0] modulus,
    output logic          tick
);

    logic [CW-1:0] cnt;

    assign tick = (cnt >= modulus - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/therm_plant.sv
// Behavioural thermal plant: heats, cools or drifts to ambient under controller commands.
module therm_plant
    import therm_pkg::*;
#(
    parameter logic [TW-1:0] T_INIT    = 16'd25,
    parameter logic [TW-1:0] AMBIENT   = 16'd22,
    parameter int unsigned   HEAT_DIV  = 4,
    parameter int unsigned   COOL_DIV  = 4,
    parameter int unsigned   DRIFT_DIV = 16,
    parameter int unsigned   MIN_RUN   = 3,
    parameter logic [TW-1:0] TMIN      = 16'd0,
    parameter logic [TW-1:0] TMAX      = 16'd120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          heat,
    input  logic          cool,
    output logic [TW-1:0] temp,
    output logic [1:0]    mode,
    output logic          conflict,
    output logic          sat
);

    localparam logic [CW-1:0] RUN_LAST = CW'(MIN_RUN - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] modulus;
    logic          tick;
    logic          state_chg;

    assign state_chg = (next_state != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (heat && !cool) begin
                    next_state = HEATING;
                end else if (cool && !heat) begin
                    next_state = COOLING;
                end
            end
            HEATING: if (!heat && run_cnt >= RUN_LAST) next_state = IDLE;
            COOLING: if (!cool && run_cnt >= RUN_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mode = state;
        sat  = (temp == TMAX) || (temp == TMIN);
    end

    always_comb begin
        unique case (state)
            HEATING: modulus = CW'(HEAT_DIV);
            COOLING: modulus = CW'(COOL_DIV);
            default: modulus = CW'(DRIFT_DIV);
        endcase
    end

    therm_rate_div u_div (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_chg),
        .modulus (modulus),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (state_chg) begin
            run_cnt <= '0;
        end else if (run_cnt < RUN_LAST) begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

    // Limits are checked before stepping so the 16-bit value can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp <= T_INIT;
        end else if (tick) begin
            unique case (state)
                HEATING: if (temp < TMAX) temp <= temp + TW'(1);
                COOLING: if (temp > TMIN) temp <= temp - TW'(1);
                default: begin
                    if (temp < AMBIENT) begin
                        temp <= temp + TW'(1);
                    end else if (temp > AMBIENT) begin
                        temp <= temp - TW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict <= 1'b0;
        end else begin
            conflict <= heat & cool;
        end
    end

endmodule

// File: tb/tb_therm_plant.sv
// Directed bench for therm_plant: default instance plus high/low saturation instances.
module tb_therm_plant;

    logic        clk;
    logic        rst_m, rst_x;
    logic        heat, cool, heat_hi, cool_lo;
    logic [15:0] temp, temp_hi, temp_lo;
    logic [1:0]  mode, mode_hi, mode_lo;
    logic        conflict, conflict_hi, conflict_lo;
    logic        sat, sat_hi, sat_lo;

    int errors = 0;
    int checks = 0;

    therm_plant dut (
        .clk(clk), .rst(rst_m), .heat(heat), .cool(cool),
        .temp(temp), .mode(mode), .conflict(conflict), .sat(sat)
    );

    therm_plant #(.T_INIT(16'd119)) dut_hi (
        .clk(clk), .rst(rst_x), .heat(heat_hi), .cool(1'b0),
        .temp(temp_hi), .mode(mode_hi), .conflict(conflict_hi), .sat(sat_hi)
    );

    therm_plant #(.T_INIT(16'd1)) dut_lo (
        .clk(clk), .rst(rst_x), .heat(1'b0), .cool(cool_lo),
        .temp(temp_lo), .mode(mode_lo), .conflict(conflict_lo), .sat(sat_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_m = 1'b1; rst_x = 1'b1;
        heat = 1'b0; cool = 1'b0; heat_hi = 1'b0; cool_lo = 1'b0;
        #12;
        chk("rst_temp", temp, 25);
        chk("rst_mode", mode, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_sat", sat, 0);
        chk("rst_temp_hi", temp_hi, 119);
        chk("rst_temp_lo", temp_lo, 1);

        // Heating from reset release; saturation instances run alongside
        step(1);
        rst_m = 1'b0; rst_x = 1'b0;
        heat = 1'b1; heat_hi = 1'b1; cool_lo = 1'b1;
        step(1);
        chk("heat_mode_e1", mode, 1);
        chk("heat_temp_e1", temp, 25);
        step(3);
        chk("heat_temp_e4", temp, 25);
        chk("hi_temp_e4", temp_hi, 119);
        chk("hi_sat_e4", sat_hi, 0);
        step(1);
        chk("heat_temp_e5", temp, 26);
        chk("hi_temp_e5", temp_hi, 120);
        chk("hi_sat_e5", sat_hi, 1);
        chk("lo_temp_e5", temp_lo, 0);
        chk("lo_sat_e5", sat_lo, 1);
        step(3);
        chk("heat_temp_e8", temp, 26);
        step(1);
        chk("heat_temp_e9", temp, 27);
        chk("hi_hold_e9", temp_hi, 120);
        chk("lo_hold_e9", temp_lo, 0);
        heat = 1'b0;
        step(1);
        chk("heat_exit_mode", mode, 0);
        chk("heat_exit_temp", temp, 27);

        // Asynchronous reset restores T_INIT without a clock edge
        #3 rst_m = 1'b1;
        #1;
        chk("async_rst_temp", temp, 25);
        chk("async_rst_mode", mode, 0);
        rst_m = 1'b0;

        // One-cycle heat pulse holds HEATING for MIN_RUN cycles
        heat = 1'b1;
        step(1);
        heat = 1'b0;
        chk("pulse_mode_e1", mode, 1);
        step(1);
        chk("pulse_mode_e2", mode, 1);
        step(1);
        chk("pulse_mode_e3", mode, 1);
        step(1);
        chk("pulse_mode_e4", mode, 0);
        chk("pulse_temp", temp, 25);

        // Both commands in IDLE: stay IDLE, conflict flag registered
        heat = 1'b1; cool = 1'b1;
        step(1);
        chk("conf_mode_1", mode, 0);
        chk("conf_flag_1", conflict, 1);
        step(1);
        chk("conf_mode_2", mode, 0);
        chk("conf_flag_2", conflict, 1);
        heat = 1'b0; cool = 1'b0;
        step(1);
        chk("conf_clear", conflict, 0);
        chk("conf_mode_3", mode, 0);

        // Idle drift from 25 toward ambient 22
        #3 rst_m = 1'b1;
        #1 rst_m = 1'b0;
        step(15);
        chk("drift_e15", temp, 25);
        step(1);
        chk("drift_e16", temp, 24);
        step(16);
        chk("drift_e32", temp, 23);
        step(15);
        chk("drift_e47", temp, 23);
        step(1);
        chk("drift_e48", temp, 22);
        step(32);
        chk("drift_hold", temp, 22);
        chk("drift_mode", mode, 0);
        chk("hi_hold_late", temp_hi, 120);
        chk("lo_hold_late", temp_lo, 0);

        // Heat 22 -> 30, then cool with a conflicting command, then reset mid-run
        heat = 1'b1;
        step(1);
        chk("e_heat_mode", mode, 1);
        step(31);
        chk("e_temp_e32", temp, 29);
        step(1);
        chk("e_temp_e33", temp, 30);
        heat = 1'b0;
        step(1);
        chk("e_idle_mode", mode, 0);
        cool = 1'b1;
        step(1);
        chk("e_cool_mode", mode, 2);
        chk("e_cool_temp", temp, 30);
        heat = 1'b1;
        step(1);
        chk("e_conf_flag", conflict, 1);
        chk("e_conf_mode", mode, 2);
        step(1);
        chk("e_conf_mode2", mode, 2);
        chk("e_conf_temp", temp, 30);
        #3 rst_m = 1'b1;
        #1;
        chk("e_rst_temp", temp, 25);
        chk("e_rst_mode", mode, 0);
        chk("e_rst_conflict", conflict, 0);
        heat = 1'b1; cool = 1'b0;
        #1 rst_m = 1'b0;
        step(1);
        chk("e_post_mode", mode, 1);
        chk("e_post_temp", temp, 25);
        chk("e_post_conflict", conflict, 0);
        step(3);
        chk("e_post_temp_e4", temp, 25);
        step(1);
        chk("e_post_temp_e5", temp, 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
